// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the host debug sequencer: command bytes, reply characters,
// FSM state encoding and a small count-saturation helper.
package mips_dbg_pkg;

   localparam logic [7:0] CMD_DUMP     = 8'h01;
   localparam logic [7:0] CMD_LOAD     = 8'h07;
   localparam logic [7:0] CMD_CONT     = 8'h08;
   localparam logic [7:0] CMD_STEPMODE = 8'h09;
   localparam logic [7:0] CMD_STEP     = 8'h0A;
   localparam logic [7:0] CMD_START    = 8'h0D;

   localparam logic [7:0] ASCII_R = 8'h52;
   localparam logic [7:0] ASCII_H = 8'h48;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_RUN       = 4'd1,
      ST_LOAD_CNT  = 4'd2,
      ST_LOAD_BYTE = 4'd3,
      ST_LOAD_WR   = 4'd4,
      ST_STEP      = 4'd5,
      ST_DUMP_RD   = 4'd6,
      ST_DUMP_TX   = 4'd7,
      ST_SEND_RDY  = 4'd8,
      ST_HALTED    = 4'd9
   } dbg_state_e;

   function automatic logic [7:0] sat_count(input logic [7:0] n, input logic [7:0] lim);
      return (n > lim) ? lim : n;
   endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// Sends NUM_BYTES bytes of a word LSB first over the UART start/done handshake.
// Start drops for one cycle after every done pulse; o_done pulses after the last byte.
module dbg_word_serializer #(
   parameter int NUM_BYTES = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_load,
   input  logic [8*NUM_BYTES-1:0] i_word,
   input  logic                   i_tx_done,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   output logic                   o_done
);

   localparam int CW = $clog2(NUM_BYTES + 1);

   logic [8*NUM_BYTES-1:0] word_q, word_d;
   logic [CW-1:0]          left_q, left_d;
   logic                   start_q, start_d;
   logic                   done_q, done_d;

   always_comb begin
      word_d  = word_q;
      left_d  = left_q;
      start_d = start_q;
      done_d  = 1'b0;
      if (i_load) begin
         word_d  = i_word;
         left_d  = CW'(NUM_BYTES);
         start_d = 1'b1;
      end else if (start_q) begin
         if (i_tx_done) begin
            start_d = 1'b0;
            word_d  = word_q >> 8;
            left_d  = left_q - CW'(1);
            done_d  = (left_q == CW'(1));
         end
      end else if (left_q != '0) begin
         start_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         word_q  <= '0;
         left_q  <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         word_q  <= word_d;
         left_q  <= left_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   assign o_tx_data  = word_q[7:0];
   assign o_tx_start = start_q;
   assign o_done     = done_q;

endmodule

// File: rtl/dbg_cmd_sequencer.sv
// Host debug sequencer: UART command decode, imem loading, run/step gating, register dump.
// Optional HALT detection is built when DBG_HALT_DETECT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command, pipeline not free-running
// RUN       | pipeline enabled, commands accepted
// LOAD_CNT  | waiting for the word-count byte
// LOAD_BYTE | collecting the 4 bytes of one program word
// LOAD_WR   | imem write strobe for the assembled word
// STEP      | single enabled cycle has elapsed, drop enable
// DUMP_RD   | register address presented, waiting for read data
// DUMP_TX   | serializing one register word
// SEND_RDY  | sending the reply byte
// HALTED    | pipeline fetched HALT, only LOAD/DUMP/STEPMODE served
module dbg_cmd_sequencer
   import mips_dbg_pkg::*;
#(
   parameter int MAX_INSTRUCTION = 64,
   parameter int ADDR_WIDTH      = 6,
   parameter int NUM_REGISTERS   = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_start,
   input  logic                  i_tx_done,
   output logic                  o_imem_we,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   output logic [31:0]           o_imem_wdata,
   output logic [4:0]            o_rf_addr,
   input  logic [31:0]           i_rf_data,
   input  logic                  i_halt,
   output logic                  o_cpu_rst,
   output logic                  o_cpu_en,
   output logic [3:0]            o_state
);

   localparam int         CW    = $clog2(MAX_INSTRUCTION + 1);
   localparam logic [7:0] MAX_N = 8'(MAX_INSTRUCTION);

   dbg_state_e            state_q, state_d;
   logic                  step_mode_q, step_mode_d;
   logic                  started_q, started_d;
   logic                  halted_q, halted_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  cpu_en_q, cpu_en_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [CW-1:0]         word_cnt_q, word_cnt_d;
   logic [CW-1:0]         word_idx_q, word_idx_d;
   logic [4:0]            rf_addr_q, rf_addr_d;
   logic                  rd_phase_q, rd_phase_d;

   logic [7:0]  n_sat;
   logic [CW-1:0] idx_nxt;
   logic [7:0]  reply_byte;
   logic        reply_load, reply_done, word_load, word_done;
   logic [7:0]  w_tx_data, r_tx_data;
   logic        w_tx_start, r_tx_start;

   assign n_sat   = sat_count(i_rx_data, MAX_N);
   assign idx_nxt = word_idx_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      step_mode_d = step_mode_q;
      started_d   = started_q;
      halted_d    = halted_q;
      cpu_rst_d   = cpu_rst_q;
      cpu_en_d    = cpu_en_q;
      imem_we_d   = 1'b0;
      imem_addr_d = imem_addr_q;
      wdata_d     = wdata_q;
      byte_cnt_d  = byte_cnt_q;
      word_cnt_d  = word_cnt_q;
      word_idx_d  = word_idx_q;
      rf_addr_d   = rf_addr_q;
      rd_phase_d  = rd_phase_q;
      reply_byte  = ASCII_R;
      word_load   = 1'b0;

      case (state_q)
         ST_IDLE, ST_RUN, ST_HALTED: begin
`ifdef DBG_HALT_DETECT_EN
            if (state_q == ST_RUN && i_halt) begin
               cpu_en_d   = 1'b0;
               halted_d   = 1'b1;
               reply_byte = ASCII_H;
               state_d    = ST_SEND_RDY;
            end else
`endif
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     cpu_rst_d = 1'b1;
                     cpu_en_d  = 1'b0;
                     started_d = 1'b0;
                     halted_d  = 1'b0;
                     state_d   = ST_LOAD_CNT;
                  end
                  CMD_START: if (!halted_q) begin
                     started_d = 1'b1;
                     cpu_rst_d = 1'b0;
                     cpu_en_d  = !step_mode_q;
                     state_d   = step_mode_q ? ST_IDLE : ST_RUN;
                  end
                  CMD_CONT: if (!halted_q) begin
                     step_mode_d = 1'b0;
                     if (started_q) begin
                        cpu_en_d = 1'b1;
                        state_d  = ST_RUN;
                     end
                  end
                  CMD_STEPMODE: begin
                     step_mode_d = 1'b1;
                     cpu_en_d    = 1'b0;
                     state_d     = halted_q ? ST_HALTED : ST_IDLE;
                  end
                  CMD_STEP: if (!halted_q) begin
                     if (started_q && step_mode_q) begin
                        cpu_en_d = 1'b1;
                        state_d  = ST_STEP;
                     end else begin
                        state_d = ST_SEND_RDY;
                     end
                  end
                  CMD_DUMP: begin
                     cpu_en_d   = 1'b0;
                     rf_addr_d  = '0;
                     rd_phase_d = 1'b0;
                     state_d    = ST_DUMP_RD;
                  end
                  default: ;
               endcase
            end
         end
         ST_LOAD_CNT: if (i_rx_valid) begin
            if (n_sat == 8'd0) begin
               state_d = ST_SEND_RDY;
            end else begin
               word_cnt_d = CW'(n_sat);
               word_idx_d = '0;
               byte_cnt_d = '0;
               state_d    = ST_LOAD_BYTE;
            end
         end
         ST_LOAD_BYTE: if (i_rx_valid) begin
            wdata_d    = {i_rx_data, wdata_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
               imem_we_d   = 1'b1;
               imem_addr_d = ADDR_WIDTH'(word_idx_q);
               state_d     = ST_LOAD_WR;
            end
         end
         ST_LOAD_WR: begin
            word_idx_d = idx_nxt;
            if (idx_nxt == word_cnt_q) begin
               state_d = ST_SEND_RDY;
            end else begin
               state_d = ST_LOAD_BYTE;
               // a fast host may already deliver the first byte of the next word
               if (i_rx_valid) begin
                  wdata_d    = {i_rx_data, wdata_q[31:8]};
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         ST_STEP: begin
            cpu_en_d = 1'b0;
            state_d  = ST_SEND_RDY;
         end
         ST_DUMP_RD: begin
            if (!rd_phase_q) begin
               rd_phase_d = 1'b1;
            end else begin
               rd_phase_d = 1'b0;
               word_load  = 1'b1;
               state_d    = ST_DUMP_TX;
            end
         end
         ST_DUMP_TX: if (word_done) begin
            if (rf_addr_q == 5'(NUM_REGISTERS - 1)) begin
               state_d = ST_SEND_RDY;
            end else begin
               rf_addr_d = rf_addr_q + 5'd1;
               state_d   = ST_DUMP_RD;
            end
         end
         ST_SEND_RDY: if (reply_done) begin
            // enable is recomputed here, which also restores it after a dump from RUN
            cpu_en_d = started_q && !step_mode_q && !halted_q;
            if (halted_q)
               state_d = ST_HALTED;
            else if (started_q && !step_mode_q)
               state_d = ST_RUN;
            else
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifndef DBG_HALT_DETECT_EN
   logic unused_halt;
   assign unused_halt = i_halt;
`endif

   assign reply_load = (state_d == ST_SEND_RDY) && (state_q != ST_SEND_RDY);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         step_mode_q <= 1'b0;
         started_q   <= 1'b0;
         halted_q    <= 1'b0;
         cpu_rst_q   <= 1'b1;
         cpu_en_q    <= 1'b0;
         imem_we_q   <= 1'b0;
         imem_addr_q <= '0;
         wdata_q     <= '0;
         byte_cnt_q  <= '0;
         word_cnt_q  <= '0;
         word_idx_q  <= '0;
         rf_addr_q   <= '0;
         rd_phase_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_mode_q <= step_mode_d;
         started_q   <= started_d;
         halted_q    <= halted_d;
         cpu_rst_q   <= cpu_rst_d;
         cpu_en_q    <= cpu_en_d;
         imem_we_q   <= imem_we_d;
         imem_addr_q <= imem_addr_d;
         wdata_q     <= wdata_d;
         byte_cnt_q  <= byte_cnt_d;
         word_cnt_q  <= word_cnt_d;
         word_idx_q  <= word_idx_d;
         rf_addr_q   <= rf_addr_d;
         rd_phase_q  <= rd_phase_d;
      end
   end

   dbg_word_serializer #(.NUM_BYTES(4)) u_word_ser (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (word_load),
      .i_word     (i_rf_data),
      .i_tx_done  (i_tx_done),
      .o_tx_data  (w_tx_data),
      .o_tx_start (w_tx_start),
      .o_done     (word_done)
   );

   dbg_word_serializer #(.NUM_BYTES(1)) u_reply_ser (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (reply_load),
      .i_word     (reply_byte),
      .i_tx_done  (i_tx_done),
      .o_tx_data  (r_tx_data),
      .o_tx_start (r_tx_start),
      .o_done     (reply_done)
   );

   assign o_tx_start   = w_tx_start | r_tx_start;
   assign o_tx_data    = r_tx_start ? r_tx_data : w_tx_data;
   assign o_imem_we    = imem_we_q;
   assign o_imem_addr  = imem_addr_q;
   assign o_imem_wdata = wdata_q;
   assign o_rf_addr    = rf_addr_q;
   assign o_cpu_rst    = cpu_rst_q;
   assign o_cpu_en     = cpu_en_q;
   assign o_state      = state_q;

endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Bench for dbg_cmd_sequencer: command table plus load/dump/reset sequences,
// TX bytes and imem writes checked against scoreboard queues.
module tb_dbg_cmd_sequencer;
   import mips_dbg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic        tx_done = 1'b0;
   logic        o_imem_we;
   logic [5:0]  o_imem_addr;
   logic [31:0] o_imem_wdata;
   logic [4:0]  o_rf_addr;
   logic [31:0] rf_data = 32'h0;
   logic        halt = 1'b0;
   logic        o_cpu_rst, o_cpu_en;
   logic [3:0]  o_state;

   dbg_cmd_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(tx_done),
      .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
      .o_rf_addr(o_rf_addr), .i_rf_data(rf_data), .i_halt(halt),
      .o_cpu_rst(o_cpu_rst), .o_cpu_en(o_cpu_en), .o_state(o_state)
   );

   always #5 clk = ~clk;

   // register-file stub with one cycle of read latency
   always @(posedge clk) rf_data <= 32'h01010101 * {27'd0, o_rf_addr};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct { logic [5:0] addr; logic [31:0] data; } imem_t;
   logic [7:0] exp_tx[$];
   imem_t      exp_imem[$];
   int we_cnt = 0, en_rises = 0, en_hi = 0, en_hi_dump = 0, dump_cyc = 0;

   // TX sink: answers each start after 3 cycles with a one-cycle done pulse
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (tx_done) begin
            tx_done = 1'b0;
            check("tx_start_drop", {31'd0, o_tx_start}, 32'd0);
         end else if (o_tx_start) begin
            wait_cnt++;
            if (wait_cnt >= 3) begin
               wait_cnt = 0;
               tx_done  = 1'b1;
               if (exp_tx.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL tx_unexpected: got %02h expected none", o_tx_data);
               end else begin
                  check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_tx.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      imem_t e;
      logic  prev_en;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (o_imem_we) begin
            we_cnt++;
            if (exp_imem.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL imem_unexpected: got addr %0d data %08h expected none", o_imem_addr, o_imem_wdata);
            end else begin
               e = exp_imem.pop_front();
               check("imem_addr", {26'd0, o_imem_addr}, {26'd0, e.addr});
               check("imem_data", o_imem_wdata, e.data);
            end
         end
         if (o_cpu_en && !prev_en) en_rises++;
         if (o_cpu_en) en_hi++;
         if (o_state == ST_DUMP_RD || o_state == ST_DUMP_TX) begin
            dump_cyc++;
            if (o_cpu_en) en_hi_dump++;
         end
         prev_en = o_cpu_en;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "timeout");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_tx.size() != 0 || o_tx_start) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, exp_tx.size(), 32'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic push_dump();
      for (int r = 0; r < 32; r++)
         for (int b = 0; b < 4; b++) exp_tx.push_back(8'(r));
      exp_tx.push_back(ASCII_R);
   endtask

   typedef struct {
      logic [7:0] cmd;
      bit         reply;
      logic       exp_rst;
      logic       exp_en;
      logic [3:0] exp_state;
      int         exp_rises;
      int         exp_hi;
   } vec_t;

   vec_t vec[13];

   initial begin
      int r0, h0, d0, c0, w0, k;
      vec[0]  = '{8'h55, 1'b0, 1'b1, 1'b0, ST_IDLE, 0, 0};
      vec[1]  = '{8'h08, 1'b0, 1'b1, 1'b0, ST_IDLE, 0, 0};
      vec[2]  = '{8'h0A, 1'b1, 1'b1, 1'b0, ST_IDLE, 0, 0};
      vec[3]  = '{8'h09, 1'b0, 1'b1, 1'b0, ST_IDLE, 0, 0};
      vec[4]  = '{8'h0D, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0};
      vec[5]  = '{8'h0A, 1'b1, 1'b0, 1'b0, ST_IDLE, 1, 1};
      vec[6]  = '{8'h0A, 1'b1, 1'b0, 1'b0, ST_IDLE, 1, 1};
      vec[7]  = '{8'h08, 1'b0, 1'b0, 1'b1, ST_RUN,  1, -1};
      vec[8]  = '{8'h09, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, -1};
      vec[9]  = '{8'h0D, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0};
      vec[10] = '{8'h08, 1'b0, 1'b0, 1'b1, ST_RUN,  1, -1};
      vec[11] = '{8'hFF, 1'b0, 1'b0, 1'b1, ST_RUN,  0, -1};
      vec[12] = '{8'h0A, 1'b1, 1'b0, 1'b1, ST_RUN,  0, -1};

      repeat (3) @(negedge clk);
      check("rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
      check("rst_cpu_en", {31'd0, o_cpu_en}, 32'd0);
      check("rst_state", {28'd0, o_state}, {28'd0, ST_IDLE});
      check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("rst_imem_we", {31'd0, o_imem_we}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         if (vec[i].reply) exp_tx.push_back(ASCII_R);
         r0 = en_rises;
         h0 = en_hi;
         send_byte(vec[i].cmd);
         wait_drain($sformatf("v%0d_drain", i), 200);
         check($sformatf("v%0d_cpu_rst", i), {31'd0, o_cpu_rst}, {31'd0, vec[i].exp_rst});
         check($sformatf("v%0d_cpu_en", i), {31'd0, o_cpu_en}, {31'd0, vec[i].exp_en});
         check($sformatf("v%0d_state", i), {28'd0, o_state}, {28'd0, vec[i].exp_state});
         check($sformatf("v%0d_en_rises", i), en_rises - r0, vec[i].exp_rises);
         if (vec[i].exp_hi >= 0)
            check($sformatf("v%0d_en_hi_cycles", i), en_hi - h0, vec[i].exp_hi);
      end

      // program load of three words
      w0 = we_cnt;
      exp_imem.push_back('{6'd0, 32'h20010006});
      exp_imem.push_back('{6'd1, 32'h0000500A});
      exp_imem.push_back('{6'd2, 32'h00000000});
      exp_tx.push_back(ASCII_R);
      send_byte(8'h07);
      send_byte(8'h03);
      foreach (exp_imem[j]) begin
         logic [31:0] w;
         w = exp_imem[j].data;
         for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
      end
      wait_drain("load_drain", 200);
      check("load_we_count", we_cnt - w0, 32'd3);
      check("load_imem_left", exp_imem.size(), 32'd0);
      check("load_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
      check("load_cpu_en", {31'd0, o_cpu_en}, 32'd0);
      check("load_state", {28'd0, o_state}, {28'd0, ST_IDLE});

      // zero-length load answers quickly with no writes
      w0 = we_cnt;
      exp_tx.push_back(ASCII_R);
      send_byte(8'h07);
      @(negedge clk);
      rx_data  = 8'h00;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      k = 0;
      while (!o_tx_start && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("load0_latency_ok", {31'd0, (k <= 2)}, 32'd1);
      wait_drain("load0_drain", 100);
      check("load0_we_count", we_cnt - w0, 32'd0);

      // dump while stopped
      d0 = en_hi_dump;
      c0 = dump_cyc;
      push_dump();
      send_byte(8'h01);
      wait_drain("dump_idle_drain", 3000);
      check("dump_idle_en_hi", en_hi_dump - d0, 32'd0);
      check("dump_idle_visited", {31'd0, (dump_cyc > c0)}, 32'd1);
      check("dump_idle_cpu_en", {31'd0, o_cpu_en}, 32'd0);
      check("dump_idle_state", {28'd0, o_state}, {28'd0, ST_IDLE});

      // continuous run, dump mid-run, resume
      send_byte(8'h0D);
      send_byte(8'h08);
      h0 = en_hi;
      repeat (20) @(negedge clk);
      check("run_en_held", en_hi - h0, 32'd20);
      check("run_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
      d0 = en_hi_dump;
      r0 = en_rises;
      push_dump();
      send_byte(8'h01);
      wait_drain("dump_run_drain", 3000);
      check("dump_run_en_hi", en_hi_dump - d0, 32'd0);
      check("dump_run_resume_rise", en_rises - r0, 32'd1);
      check("dump_run_cpu_en", {31'd0, o_cpu_en}, 32'd1);
      check("dump_run_state", {28'd0, o_state}, {28'd0, ST_RUN});

      // reset in the middle of a load, then a fresh load starts at address 0
      send_byte(8'h07);
      send_byte(8'h02);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
      check("mid_rst_cpu_en", {31'd0, o_cpu_en}, 32'd0);
      check("mid_rst_state", {28'd0, o_state}, {28'd0, ST_IDLE});
      check("mid_rst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("mid_rst_imem_addr", {26'd0, o_imem_addr}, 32'd0);
      check("mid_rst_imem_wdata", o_imem_wdata, 32'd0);
      check("mid_rst_rf_addr", {27'd0, o_rf_addr}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_imem.push_back('{6'd0, 32'h44332211});
      exp_tx.push_back(ASCII_R);
      send_byte(8'h07);
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      wait_drain("reload_drain", 200);
      check("reload_imem_left", exp_imem.size(), 32'd0);
      check("reload_state", {28'd0, o_state}, {28'd0, ST_IDLE});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
